// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated four-approach phase scheduler.
// Round-robin green service with min/max green, yellow and all-red
// clearance, plus emergency-vehicle preemption. All durations are
// counted in tick enables; the light heads are a Moore decode of state/cur.
module traffic_phase_scheduler #(
    parameter int GREEN_MIN = 3,
    parameter int GREEN_MAX = 7,
    parameter int YELLOW    = 2,
    parameter int ALLRED    = 1,
    parameter int CW        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] req,
    input  logic       emg,
    input  logic [1:0] emg_dir,
    output logic [2:0] light_S1,
    output logic [2:0] light_S2,
    output logic [2:0] light_S3,
    output logic [2:0] light_S4,
    output logic [1:0] phase_id,
    output logic       preempt_active
);

    // Terminal counts: a phase ends on the tick that sees cnt at its last value.
    localparam logic [CW-1:0] GMIN_LAST = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] GMAX_LAST = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] YEL_LAST  = CW'(YELLOW - 1);
    localparam logic [CW-1:0] AR_LAST   = CW'(ALLRED - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [2:0] HEAD_GREEN  = 3'b001;
    localparam logic [2:0] HEAD_YELLOW = 3'b010;
    localparam logic [2:0] HEAD_RED    = 3'b100;

    typedef enum logic [1:0] {
        ST_ALLRED  = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_PREEMPT = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    cur, cur_n;
    logic [3:0]    pend, pend_n;
    logic          emg_q;
    logic [1:0]    emg_dir_q;
    logic [3:0]    dem;
    logic [3:0]    others;
    logic [2:0]    head [4];

    // Round-robin pick: first set demand bit after 'from', 'from' itself last.
    // Iterating from the farthest offset down lets the nearest one win.
    function automatic logic [1:0] next_grant(input logic [3:0] d, input logic [1:0] from);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = from;
        for (int k = 4; k >= 1; k--) begin
            idx = from + 2'(k);
            if (d[idx]) pick = idx;
        end
        return pick;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    assign dem    = pend | req;
    assign others = dem & ~onehot(cur);

    // Next-state and timer logic for the phase sequencer.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cur_n   = cur;
        unique case (state)
            ST_ALLRED: begin
                if (tick) begin
                    if (cnt == AR_LAST) begin
                        if (emg_q) begin
                            state_n = ST_PREEMPT;
                            cur_n   = emg_dir_q;
                            cnt_n   = '0;
                        end else if (|dem) begin
                            state_n = ST_GREEN;
                            cur_n   = next_grant(dem, cur);
                            cnt_n   = '0;
                        end
                        // No demand: hold at the last count and re-evaluate each tick.
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            ST_GREEN: begin
                if (emg_q) begin
                    // Preempt abort is immediate and ignores min green.
                    state_n = (cur == emg_dir_q) ? ST_PREEMPT : ST_YELLOW;
                    cnt_n   = '0;
                end else if (tick) begin
                    if ((cnt == GMAX_LAST) || ((cnt >= GMIN_LAST) && (|others))) begin
                        state_n = ST_YELLOW;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            ST_YELLOW: begin
                if (tick) begin
                    if (cnt == YEL_LAST) begin
                        state_n = ST_ALLRED;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            ST_PREEMPT: begin
                if (!emg_q) begin
                    state_n = ST_YELLOW;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = ST_ALLRED;
                cnt_n   = '0;
            end
        endcase
    end

    // Request latching; the clear on green/preempt entry beats a same-cycle set.
    always_comb begin
        pend_n = pend | req;
        if ((state_n != state) && ((state_n == ST_GREEN) || (state_n == ST_PREEMPT))) begin
            pend_n[cur_n] = 1'b0;
        end
    end

    // Sequencer registers and emergency input capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ALLRED;
            cnt       <= '0;
            cur       <= 2'd3;
            pend      <= '0;
            emg_q     <= 1'b0;
            emg_dir_q <= 2'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cur   <= cur_n;
            pend  <= pend_n;
            emg_q <= emg;
            // Direction is captured only on the emg rising edge and frozen while held.
            if (emg && !emg_q) emg_dir_q <= emg_dir;
        end
    end

    // Moore decode of the light heads: at most one non-red head.
    always_comb begin
        for (int i = 0; i < 4; i++) head[i] = HEAD_RED;
        unique case (state)
            ST_GREEN, ST_PREEMPT: head[cur] = HEAD_GREEN;
            ST_YELLOW:            head[cur] = HEAD_YELLOW;
            default:              ;
        endcase
    end

    assign light_S1       = head[0];
    assign light_S2       = head[1];
    assign light_S3       = head[2];
    assign light_S4       = head[3];
    assign phase_id       = cur;
    assign preempt_active = (state == ST_PREEMPT);

endmodule
